// File: rtl/cndm_proto_pkg.sv
// ============================================================================
// Module      : cndm_proto_pkg
// Description : Shared types and defaults for the completion IRQ moderation path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cndm_proto_pkg;

    typedef enum logic [1:0] {
        ST_DISARMED = 2'd0,
        ST_IDLE     = 2'd1,
        ST_COAL     = 2'd2,
        ST_FIRE     = 2'd3
    } irq_mod_state_t;

    localparam int unsigned DEFAULT_PRESCALE = 250;

endpackage

`default_nettype wire

// File: rtl/cndm_proto_us_tick.sv
// ============================================================================
// Module      : cndm_proto_us_tick
// Description : Prescaler emitting a one-cycle tick every PRESCALE enabled cycles.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cndm_proto_us_tick
    import cndm_proto_pkg::*;
#(
    parameter int unsigned PRESCALE = DEFAULT_PRESCALE
) (
    input  logic clk,
    input  logic rst,
    input  logic restart_i,
    input  logic en_i,
    output logic tick_o
);

    localparam int unsigned    C_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [C_W-1:0] C_LAST = C_W'(PRESCALE - 1);

    logic [C_W-1:0] cnt_q;
    logic [C_W-1:0] cnt_d;

    assign tick_o = en_i && !restart_i && (cnt_q == C_LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (restart_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = (cnt_q == C_LAST) ? '0 : cnt_q + C_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/cndm_proto_irq_mod.sv
// ============================================================================
// Module      : cndm_proto_irq_mod
// Description : Completion interrupt moderation: coalesces events by count and
//               microsecond holdoff, issues one MSI request per armed window.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cndm_proto_irq_mod
    import cndm_proto_pkg::*;
#(
    parameter int unsigned CNT_W    = 8,
    parameter int unsigned TMR_W    = 16,
    parameter int unsigned PRESCALE = DEFAULT_PRESCALE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             irq_in,
    input  logic             cfg_en,
    input  logic [CNT_W-1:0] cfg_cnt_thresh,
    input  logic [TMR_W-1:0] cfg_tmr_thresh,
    input  logic             arm,
    output logic             msi_valid,
    input  logic             msi_ready,
    output logic [CNT_W-1:0] msi_count,
    output logic             armed,
    output logic [31:0]      stat_irq_cnt
);

    localparam logic [CNT_W-1:0] C_CNT_MAX = '1;
    localparam logic [TMR_W-1:0] C_TMR_MAX = '1;

    irq_mod_state_t   state_q;
    irq_mod_state_t   state_d;
    logic [CNT_W-1:0] ev_cnt_q;
    logic [CNT_W-1:0] ev_cnt_d;
    logic [CNT_W-1:0] msi_count_q;
    logic [CNT_W-1:0] msi_count_d;
    logic [TMR_W-1:0] tmr_q;
    logic [TMR_W-1:0] tmr_d;
    logic [31:0]      stat_q;
    logic [31:0]      stat_d;

    logic [CNT_W-1:0] w_nxt;
    logic [CNT_W-1:0] w_thr;
    logic             w_cnt_hit;
    logic             w_tmr_hit;
    logic             w_tick;
    logic             w_in_coal;

    assign w_in_coal = (state_q == ST_COAL);

    // Prescaler runs only while a window is open and sits at zero otherwise,
    // so every COAL entry starts a fresh microsecond.
    cndm_proto_us_tick #(
        .PRESCALE (PRESCALE)
    ) u_us_tick (
        .clk       (clk),
        .rst       (rst),
        .restart_i (!w_in_coal),
        .en_i      (w_in_coal),
        .tick_o    (w_tick)
    );

    assign w_nxt     = (irq_in && (ev_cnt_q != C_CNT_MAX)) ? ev_cnt_q + CNT_W'(1) : ev_cnt_q;
    assign w_thr     = (cfg_cnt_thresh == '0) ? CNT_W'(1) : cfg_cnt_thresh;
    assign w_cnt_hit = (w_nxt >= w_thr);
    assign w_tmr_hit = (cfg_tmr_thresh != '0) && (tmr_q >= cfg_tmr_thresh);

    always_comb begin
        state_d     = state_q;
        ev_cnt_d    = ev_cnt_q;
        msi_count_d = msi_count_q;
        tmr_d       = tmr_q;
        stat_d      = stat_q;

        if (w_in_coal && w_tick && (tmr_q != C_TMR_MAX)) begin
            tmr_d = tmr_q + TMR_W'(1);
        end

        case (state_q)
            ST_DISARMED: begin
                if (cfg_en) begin
                    ev_cnt_d = w_nxt;
                    if (arm) begin
                        if (w_cnt_hit) begin
                            state_d     = ST_FIRE;
                            msi_count_d = w_nxt;
                            ev_cnt_d    = '0;
                        end else if (w_nxt != '0) begin
                            state_d = ST_COAL;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
            end

            ST_IDLE, ST_COAL: begin
                if (!cfg_en) begin
                    state_d  = ST_DISARMED;
                    ev_cnt_d = '0;
                end else if (w_cnt_hit || (w_in_coal && w_tmr_hit)) begin
                    state_d     = ST_FIRE;
                    msi_count_d = w_nxt;
                    ev_cnt_d    = '0;
                end else begin
                    ev_cnt_d = w_nxt;
                    if (w_nxt != '0) begin
                        state_d = ST_COAL;
                    end
                end
            end

            ST_FIRE: begin
                // Events seen while the request is outstanding seed the next window.
                if (cfg_en) begin
                    ev_cnt_d = w_nxt;
                end
                if (msi_ready) begin
                    state_d = ST_DISARMED;
                    stat_d  = stat_q + 32'd1;
                end
            end

            default: begin
                state_d = ST_DISARMED;
            end
        endcase

        if (state_d != ST_COAL) begin
            tmr_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_DISARMED;
            ev_cnt_q    <= '0;
            msi_count_q <= '0;
            tmr_q       <= '0;
            stat_q      <= '0;
        end else begin
            state_q     <= state_d;
            ev_cnt_q    <= ev_cnt_d;
            msi_count_q <= msi_count_d;
            tmr_q       <= tmr_d;
            stat_q      <= stat_d;
        end
    end

    assign msi_valid    = (state_q == ST_FIRE);
    assign armed        = (state_q == ST_IDLE) || (state_q == ST_COAL);
    assign msi_count    = msi_count_q;
    assign stat_irq_cnt = stat_q;

endmodule

`default_nettype wire

// File: tb/tb_cndm_proto_irq_mod.sv
// ============================================================================
// Module      : tb_cndm_proto_irq_mod
// Description : Self-checking bench for the interrupt moderation block.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cndm_proto_irq_mod;

    localparam int CNT_W = 4;
    localparam int TMR_W = 16;
    localparam int PRESC = 10;
    localparam int CMAX  = 15;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             irq_in = 1'b0;
    logic             cfg_en = 1'b0;
    logic [CNT_W-1:0] cfg_cnt_thresh = '0;
    logic [TMR_W-1:0] cfg_tmr_thresh = '0;
    logic             arm = 1'b0;
    logic             msi_ready = 1'b0;
    logic             msi_valid;
    logic [CNT_W-1:0] msi_count;
    logic             armed;
    logic [31:0]      stat_irq_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model: window bookkeeping in plain integers.
    int          m_ev;
    int          m_count;
    int          m_age;
    int unsigned m_stat;
    bit          m_armed;
    bit          m_req;

    cndm_proto_irq_mod #(
        .CNT_W    (CNT_W),
        .TMR_W    (TMR_W),
        .PRESCALE (PRESC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .irq_in         (irq_in),
        .cfg_en         (cfg_en),
        .cfg_cnt_thresh (cfg_cnt_thresh),
        .cfg_tmr_thresh (cfg_tmr_thresh),
        .arm            (arm),
        .msi_valid      (msi_valid),
        .msi_ready      (msi_ready),
        .msi_count      (msi_count),
        .armed          (armed),
        .stat_irq_cnt   (stat_irq_cnt)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_ev = 0; m_count = 0; m_age = 0; m_stat = 0; m_armed = 0; m_req = 0;
    endtask

    task automatic model_fire(input int n);
        m_count = n; m_ev = 0; m_req = 1; m_armed = 0;
    endtask

    task automatic model_step();
        int  thr;
        int  nxt;
        bit  pending;
        thr = (cfg_cnt_thresh == 0) ? 1 : int'(cfg_cnt_thresh);
        nxt = m_ev + int'(irq_in);
        if (nxt > CMAX) nxt = CMAX;
        if (m_req) begin
            if (cfg_en) m_ev = nxt;
            if (msi_ready) begin
                m_req = 0;
                m_stat++;
            end
        end else if (!m_armed) begin
            if (cfg_en) begin
                m_ev = nxt;
                if (arm) begin
                    if (nxt >= thr) model_fire(nxt);
                    else begin
                        m_armed = 1;
                        m_age   = 0;
                    end
                end
            end
        end else if (!cfg_en) begin
            m_armed = 0;
            m_ev    = 0;
        end else begin
            pending = (m_ev > 0);
            if (nxt >= thr ||
                (pending && cfg_tmr_thresh != 0 && m_age >= int'(cfg_tmr_thresh) * PRESC)) begin
                model_fire(nxt);
            end else begin
                if (pending) m_age++;
                else m_age = 0;
                m_ev = nxt;
            end
        end
    endtask

    // Drive one cycle of stimulus; returns at the following falling edge.
    task automatic cycle(input logic irq, input logic a, input logic rdy);
        irq_in    = irq;
        arm       = a;
        msi_ready = rdy;
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        model_reset();
        checks++;
        if (msi_valid !== 1'b0 || armed !== 1'b0 || msi_count !== '0 || stat_irq_cnt !== 32'd0) begin
            errors++;
            $display("FAIL reset: valid=%b armed=%b count=%0d stat=%0d, required all zero",
                     msi_valid, armed, msi_count, stat_irq_cnt);
        end
        rst = 1'b0;
        cycle(0, 0, 0);
        checks++;
        if (armed !== 1'b0 || msi_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: armed=%b valid=%b, required 0 0", armed, msi_valid);
        end
    endtask

    task automatic test_count_thresh();
        int nvalid;
        cfg_en = 1; cfg_cnt_thresh = 4; cfg_tmr_thresh = 0;
        cycle(0, 1, 1);
        checks++;
        if (armed !== 1'b1) begin
            errors++;
            $display("FAIL cnt_arm: armed=%b, required 1", armed);
        end
        nvalid = 0;
        for (int i = 0; i < 4; i++) begin
            if (msi_valid) nvalid++;
            cycle(1, 0, 1);
        end
        checks++;
        if (msi_valid !== 1'b1 || msi_count !== 4'd4) begin
            errors++;
            $display("FAIL cnt_fire: valid=%b count=%0d, required 1 4", msi_valid, msi_count);
        end
        for (int i = 0; i < 3; i++) begin
            if (msi_valid) nvalid++;
            cycle(0, 0, 1);
        end
        checks++;
        if (nvalid != 1 || stat_irq_cnt !== 32'd1 || armed !== 1'b0 || msi_count !== 4'd4) begin
            errors++;
            $display("FAIL cnt_done: valid_cycles=%0d stat=%0d armed=%b count=%0d, required 1 1 0 4",
                     nvalid, stat_irq_cnt, armed, msi_count);
        end
    endtask

    task automatic test_timer();
        int d;
        cfg_cnt_thresh = 15; cfg_tmr_thresh = 3;
        cycle(0, 1, 0);
        cycle(1, 0, 0);
        d = 1;
        while (!msi_valid && d < 60) begin
            cycle(0, 0, 0);
            d++;
        end
        checks++;
        if (d < 3 * PRESC + 1 || d > 3 * PRESC + 3 || msi_count !== 4'd1) begin
            errors++;
            $display("FAIL timer: latency=%0d count=%0d, required latency %0d..%0d count 1",
                     d, msi_count, 3 * PRESC + 1, 3 * PRESC + 3);
        end
        cycle(0, 0, 1);
        checks++;
        if (stat_irq_cnt !== 32'd2 || msi_valid !== 1'b0) begin
            errors++;
            $display("FAIL timer_accept: stat=%0d valid=%b, required 2 0", stat_irq_cnt, msi_valid);
        end
    endtask

    task automatic test_backpressure();
        bit steady;
        cfg_cnt_thresh = 1; cfg_tmr_thresh = 0;
        cycle(1, 1, 0);
        checks++;
        if (msi_valid !== 1'b1 || msi_count !== 4'd1) begin
            errors++;
            $display("FAIL bp_fire: valid=%b count=%0d, required 1 1", msi_valid, msi_count);
        end
        steady = 1;
        for (int i = 0; i < 20; i++) begin
            cycle((i % 4) == 0, 0, 0);
            if (msi_valid !== 1'b1 || msi_count !== 4'd1) steady = 0;
        end
        checks++;
        if (!steady) begin
            errors++;
            $display("FAIL bp_hold: valid=%b count=%0d, required held 1 1", msi_valid, msi_count);
        end
        cycle(0, 0, 1);
        checks++;
        if (stat_irq_cnt !== 32'd3 || msi_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_accept: stat=%0d valid=%b, required 3 0", stat_irq_cnt, msi_valid);
        end
        cfg_cnt_thresh = 5;
        cycle(0, 1, 0);
        checks++;
        if (msi_valid !== 1'b1 || msi_count !== 4'd5) begin
            errors++;
            $display("FAIL bp_rearm: valid=%b count=%0d, required 1 5", msi_valid, msi_count);
        end
        cycle(0, 0, 1);
    endtask

    task automatic test_saturation();
        cfg_cnt_thresh = 1;
        for (int i = 0; i < 20; i++) cycle(1, 0, 0);
        checks++;
        if (armed !== 1'b0 || msi_valid !== 1'b0) begin
            errors++;
            $display("FAIL sat_idle: armed=%b valid=%b, required 0 0", armed, msi_valid);
        end
        cycle(0, 1, 0);
        checks++;
        if (msi_valid !== 1'b1 || msi_count !== 4'd15) begin
            errors++;
            $display("FAIL sat_fire: valid=%b count=%0d, required 1 15", msi_valid, msi_count);
        end
        cycle(0, 0, 1);
        checks++;
        if (stat_irq_cnt !== 32'd5) begin
            errors++;
            $display("FAIL sat_accept: stat=%0d, required 5", stat_irq_cnt);
        end
    endtask

    task automatic test_disable();
        bit held;
        cfg_cnt_thresh = 10; cfg_tmr_thresh = 0;
        cycle(0, 1, 1);
        cycle(1, 0, 1);
        cycle(1, 0, 1);
        cfg_en = 0;
        cycle(0, 0, 1);
        checks++;
        if (armed !== 1'b0 || msi_valid !== 1'b0) begin
            errors++;
            $display("FAIL dis_coal: armed=%b valid=%b, required 0 0", armed, msi_valid);
        end
        cycle(0, 1, 1);
        checks++;
        if (armed !== 1'b0) begin
            errors++;
            $display("FAIL dis_arm_ignored: armed=%b, required 0", armed);
        end
        cfg_en = 1; cfg_cnt_thresh = 1;
        cycle(0, 1, 1);
        checks++;
        if (armed !== 1'b1 || msi_valid !== 1'b0) begin
            errors++;
            $display("FAIL dis_cleared: armed=%b valid=%b, required 1 0", armed, msi_valid);
        end
        cycle(1, 0, 0);
        cfg_en = 0;
        held = msi_valid;
        for (int i = 0; i < 3; i++) begin
            cycle(0, 0, 0);
            if (msi_valid !== 1'b1) held = 0;
        end
        checks++;
        if (!held) begin
            errors++;
            $display("FAIL dis_fire_hold: valid=%b, required held 1", msi_valid);
        end
        cycle(0, 0, 1);
        checks++;
        if (msi_valid !== 1'b0 || stat_irq_cnt !== 32'd6) begin
            errors++;
            $display("FAIL dis_fire_done: valid=%b stat=%0d, required 0 6", msi_valid, stat_irq_cnt);
        end
        cfg_en = 1;
    endtask

    task automatic test_async_reset();
        cfg_cnt_thresh = 1;
        cycle(0, 1, 0);
        cycle(1, 0, 0);
        checks++;
        if (msi_valid !== 1'b1) begin
            errors++;
            $display("FAIL ar_setup: valid=%b, required 1", msi_valid);
        end
        #2 rst = 1'b1;
        #1;
        model_reset();
        checks++;
        if (msi_valid !== 1'b0 || armed !== 1'b0 || stat_irq_cnt !== 32'd0) begin
            errors++;
            $display("FAIL async_reset: valid=%b armed=%b stat=%0d, required 0 0 0",
                     msi_valid, armed, stat_irq_cnt);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_random();
        int bad;
        bad = 0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 39) == 0) cfg_cnt_thresh = CNT_W'($urandom_range(0, 8));
            if ($urandom_range(0, 39) == 0) cfg_tmr_thresh = TMR_W'($urandom_range(0, 4));
            cfg_en = ($urandom_range(0, 29) != 0);
            cycle($urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 2) != 0);
            checks++;
            if (msi_valid !== m_req || armed !== m_armed ||
                msi_count !== CNT_W'(m_count) || stat_irq_cnt !== m_stat) begin
                errors++;
                if (bad < 10)
                    $display("FAIL random[%0d]: valid=%b armed=%b count=%0d stat=%0d, required %b %b %0d %0d",
                             i, msi_valid, armed, msi_count, stat_irq_cnt,
                             m_req, m_armed, m_count, m_stat);
                bad++;
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_count_thresh();
        test_timer();
        test_backpressure();
        test_saturation();
        test_disable();
        test_async_reset();
        cfg_en = 1; cfg_cnt_thresh = 3; cfg_tmr_thresh = 2;
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
